// File: rtl/refresh_exec_if.sv
// Bundle of refresh-request, user-access and GC-DRAM array signals for refresh_exec.
// The statistics counters exist only when REFRESH_EXEC_STATS_EN is defined.
interface refresh_exec_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              ref_valid;
  logic [ADDR_W-1:0] ref_addr;
  logic              ref_skip;
  logic              ref_ready;
  logic              ref_done;
  logic              user_read_en;
  logic              user_write_en;
  logic [ADDR_W-1:0] user_addr;
  logic [DATA_W-1:0] user_wdata;
  logic [DATA_W-1:0] user_rdata;
  logic              user_rvalid;
  logic              arr_re;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic              busy;
`ifdef REFRESH_EXEC_STATS_EN
  logic [15:0]       ref_count;
  logic [15:0]       stall_count;

  modport master (
    output ref_valid, ref_addr, ref_skip, user_read_en, user_write_en,
           user_addr, user_wdata, arr_rdata,
    input  ref_ready, ref_done, user_rdata, user_rvalid, arr_re, arr_we,
           arr_addr, arr_wdata, busy, ref_count, stall_count
  );
  modport slave (
    input  ref_valid, ref_addr, ref_skip, user_read_en, user_write_en,
           user_addr, user_wdata, arr_rdata,
    output ref_ready, ref_done, user_rdata, user_rvalid, arr_re, arr_we,
           arr_addr, arr_wdata, busy, ref_count, stall_count
  );
`else
  modport master (
    output ref_valid, ref_addr, ref_skip, user_read_en, user_write_en,
           user_addr, user_wdata, arr_rdata,
    input  ref_ready, ref_done, user_rdata, user_rvalid, arr_re, arr_we,
           arr_addr, arr_wdata, busy
  );
  modport slave (
    input  ref_valid, ref_addr, ref_skip, user_read_en, user_write_en,
           user_addr, user_wdata, arr_rdata,
    output ref_ready, ref_done, user_rdata, user_rvalid, arr_re, arr_we,
           arr_addr, arr_wdata, busy
  );
`endif
endinterface

// File: rtl/refresh_exec.sv
// Row refresh executor for a GC-DRAM array: read, capture, write back, with user priority.
// Optional statistics counters are enabled by defining REFRESH_EXEC_STATS_EN.
//   state | meaning
//   IDLE  | waiting for a refresh request; skip requests complete here
//   RD    | issue refresh read of latched row (stalls on user access)
//   CAP   | capture array read data
//   WB    | write captured data back (stalls on user access)
module refresh_exec #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input logic          clk,
  input logic          rst_n,
  refresh_exec_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, CAP, WB} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_rvalid;
  logic              w_user, w_ready, w_xfer, w_wr_hit, w_drop, w_wb_fire, w_stall;

  assign w_user    = bus.user_read_en | bus.user_write_en;
  assign w_ready   = (r_state == IDLE) & ~w_user;
  assign w_xfer    = bus.ref_valid & w_ready;
  assign w_wr_hit  = bus.user_write_en & (bus.user_addr == r_addr);
  // A user write to the row being refreshed makes the captured copy stale.
  assign w_drop    = w_wr_hit & ((r_state == CAP) | (r_state == WB));
  assign w_wb_fire = (r_state == WB) & ~w_user;
  assign w_stall   = ((r_state == RD) | (r_state == WB)) & w_user & ~w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_done   <= (w_xfer & bus.ref_skip) | w_wb_fire | w_drop;
      r_rvalid <= bus.user_read_en & ~bus.user_write_en;
      if (w_xfer)           r_addr <= bus.ref_addr;
      if (r_state == CAP)   r_data <= bus.arr_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_xfer && !bus.ref_skip) w_next = RD;
      RD:   if (!w_user) w_next = CAP;
      CAP:  w_next = w_drop ? IDLE : WB;
      WB:   if (w_drop || !w_user) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // User strobes pass straight to the array; refresh only uses idle array cycles.
  always_comb begin
    bus.arr_re    = 1'b0;
    bus.arr_we    = 1'b0;
    bus.arr_addr  = '0;
    bus.arr_wdata = '0;
    if (rst_n) begin
      if (w_user) begin
        bus.arr_we   = bus.user_write_en;
        bus.arr_re   = bus.user_read_en & ~bus.user_write_en;
        bus.arr_addr = bus.user_addr;
        if (bus.user_write_en) bus.arr_wdata = bus.user_wdata;
      end else if (r_state == RD) begin
        bus.arr_re   = 1'b1;
        bus.arr_addr = r_addr;
      end else if (r_state == WB) begin
        bus.arr_we    = 1'b1;
        bus.arr_addr  = r_addr;
        bus.arr_wdata = r_data;
      end
    end
  end

  assign bus.ref_ready   = rst_n & w_ready;
  assign bus.ref_done    = r_done;
  assign bus.busy        = (r_state != IDLE);
  assign bus.user_rvalid = r_rvalid;
  assign bus.user_rdata  = r_rvalid ? bus.arr_rdata : '0;

`ifdef REFRESH_EXEC_STATS_EN
  logic [15:0] r_ref_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_wb_fire && r_ref_cnt != 16'hFFFF)   r_ref_cnt   <= r_ref_cnt + 16'd1;
      if (w_stall && r_stall_cnt != 16'hFFFF)   r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.ref_count   = r_ref_cnt;
  assign bus.stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_refresh_exec.sv
// Directed self-checking bench for refresh_exec with a behavioural GC-DRAM array model.
// Array row i is preloaded with {4{i}}, except row 0x05 which holds 0xA5A5A5A5.
module tb_refresh_exec;
  logic clk = 1'b0;
  logic rst_n;
  logic tb_init;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] mem [128];

  refresh_exec_if #(.DATA_W(32), .ADDR_W(7)) bus ();

  refresh_exec #(.DATA_W(32), .ADDR_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 128; i++)
        mem[i] <= (i == 5) ? 32'hA5A5A5A5 : {4{8'(i)}};
      bus.arr_rdata <= 32'hDEADBEEF;
    end else begin
      if (bus.arr_we) mem[bus.arr_addr] <= bus.arr_wdata;
      bus.arr_rdata <= bus.arr_re ? mem[bus.arr_addr] : 32'hDEADBEEF;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ref_valid = 0; bus.ref_skip = 0; bus.ref_addr = '0;
    bus.user_read_en = 0; bus.user_write_en = 0; bus.user_addr = '0; bus.user_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; tb_init = 1; idle_inputs();
    repeat (3) tick();
    bus.user_read_en = 1; bus.ref_valid = 1; bus.user_addr = 7'h11;
    #1;
    n_tests++;
    if ({bus.ref_ready, bus.ref_done, bus.arr_re, bus.arr_we, bus.busy, bus.user_rvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/done/re/we/busy/rv=%b exp 000000",
               {bus.ref_ready, bus.ref_done, bus.arr_re, bus.arr_we, bus.busy, bus.user_rvalid});
    end
    n_tests++;
    if ({bus.arr_addr, bus.arr_wdata, bus.user_rdata} !== 71'b0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h exp 0", bus.arr_addr, bus.arr_wdata, bus.user_rdata);
    end
    tick(); idle_inputs(); tb_init = 0; rst_n = 1;
    #1;
    n_tests++;
    if (bus.ref_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b exp 1", bus.ref_ready);
    end
  endtask

  task automatic test_refresh();
    tick(); bus.ref_valid = 1; bus.ref_skip = 0; bus.ref_addr = 7'h05; #1;
    tick(); bus.ref_valid = 0; #1;
    n_tests++;
    if ({bus.arr_re, bus.arr_we, bus.arr_addr} !== {1'b1, 1'b0, 7'h05}) begin
      n_fail++; $display("FAIL ref_rd: got re=%b we=%b addr=%h exp re=1 we=0 addr=05", bus.arr_re, bus.arr_we, bus.arr_addr);
    end
    tick(); #1;
    n_tests++;
    if ({bus.arr_re, bus.arr_we, bus.busy} !== 3'b001) begin
      n_fail++; $display("FAIL ref_cap: got re=%b we=%b busy=%b exp 0 0 1", bus.arr_re, bus.arr_we, bus.busy);
    end
    tick(); #1;
    n_tests++;
    if ({bus.arr_we, bus.arr_addr, bus.arr_wdata} !== {1'b1, 7'h05, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL ref_wb: got we=%b addr=%h wdata=%h exp 1 05 a5a5a5a5", bus.arr_we, bus.arr_addr, bus.arr_wdata);
    end
    tick(); #1;
    n_tests++;
    if ({bus.ref_done, bus.busy, bus.arr_we} !== 3'b100) begin
      n_fail++; $display("FAIL ref_done: got done=%b busy=%b we=%b exp 1 0 0", bus.ref_done, bus.busy, bus.arr_we);
    end
    tick(); #1;
    n_tests++;
    if (bus.ref_done !== 1'b0) begin
      n_fail++; $display("FAIL ref_done_pulse: got %b exp 0", bus.ref_done);
    end
  endtask

  task automatic test_skip();
    tick(); bus.ref_valid = 1; bus.ref_skip = 1; bus.ref_addr = 7'h10; #1;
    n_tests++;
    if ({bus.ref_ready, bus.arr_re, bus.arr_we} !== 3'b100) begin
      n_fail++; $display("FAIL skip_xfer: got rdy=%b re=%b we=%b exp 1 0 0", bus.ref_ready, bus.arr_re, bus.arr_we);
    end
    tick(); bus.ref_valid = 0; bus.ref_skip = 0; #1;
    n_tests++;
    if ({bus.ref_done, bus.arr_re, bus.arr_we, bus.busy} !== 4'b1000) begin
      n_fail++; $display("FAIL skip_done: got done=%b re=%b we=%b busy=%b exp 1 0 0 0",
                         bus.ref_done, bus.arr_re, bus.arr_we, bus.busy);
    end
  endtask

  task automatic test_user_stall_wb();
    tick(); bus.ref_valid = 1; bus.ref_addr = 7'h20; #1;
    tick(); bus.ref_valid = 0; #1;
    tick(); #1;
    tick(); bus.user_read_en = 1; bus.user_addr = 7'h30; #1;
    n_tests++;
    if ({bus.arr_re, bus.arr_we, bus.arr_addr, bus.ref_ready} !== {1'b1, 1'b0, 7'h30, 1'b0}) begin
      n_fail++; $display("FAIL wbstall_rd1: got re=%b we=%b addr=%h rdy=%b exp 1 0 30 0",
                         bus.arr_re, bus.arr_we, bus.arr_addr, bus.ref_ready);
    end
    tick(); #1;
    n_tests++;
    if ({bus.arr_re, bus.user_rvalid, bus.user_rdata, bus.busy} !== {1'b1, 1'b1, 32'h30303030, 1'b1}) begin
      n_fail++; $display("FAIL wbstall_rd2: got re=%b rv=%b rdata=%h busy=%b exp 1 1 30303030 1",
                         bus.arr_re, bus.user_rvalid, bus.user_rdata, bus.busy);
    end
    tick(); bus.user_read_en = 0; #1;
    n_tests++;
    if ({bus.arr_we, bus.arr_addr, bus.arr_wdata, bus.user_rvalid} !== {1'b1, 7'h20, 32'h20202020, 1'b1}) begin
      n_fail++; $display("FAIL wbstall_wb: got we=%b addr=%h wdata=%h rv=%b exp 1 20 20202020 1",
                         bus.arr_we, bus.arr_addr, bus.arr_wdata, bus.user_rvalid);
    end
    tick(); #1;
    n_tests++;
    if ({bus.ref_done, bus.user_rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL wbstall_done: got done=%b rv=%b exp 1 0", bus.ref_done, bus.user_rvalid);
    end
  endtask

  task automatic test_rd_stall();
    tick(); bus.ref_valid = 1; bus.ref_addr = 7'h40; #1;
    tick(); bus.ref_valid = 0; bus.user_read_en = 1; bus.user_addr = 7'h41; #1;
    n_tests++;
    if ({bus.arr_re, bus.arr_addr} !== {1'b1, 7'h41}) begin
      n_fail++; $display("FAIL rdstall_user: got re=%b addr=%h exp 1 41", bus.arr_re, bus.arr_addr);
    end
    tick(); bus.user_read_en = 0; #1;
    n_tests++;
    if ({bus.arr_re, bus.arr_addr, bus.user_rvalid, bus.user_rdata} !== {1'b1, 7'h40, 1'b1, 32'h41414141}) begin
      n_fail++; $display("FAIL rdstall_reissue: got re=%b addr=%h rv=%b rdata=%h exp 1 40 1 41414141",
                         bus.arr_re, bus.arr_addr, bus.user_rvalid, bus.user_rdata);
    end
    tick(); #1;
    tick(); #1;
    n_tests++;
    if ({bus.arr_we, bus.arr_addr, bus.arr_wdata} !== {1'b1, 7'h40, 32'h40404040}) begin
      n_fail++; $display("FAIL rdstall_wb: got we=%b addr=%h wdata=%h exp 1 40 40404040", bus.arr_we, bus.arr_addr, bus.arr_wdata);
    end
    tick(); #1;
  endtask

  task automatic test_wr_hit_cap();
    tick(); bus.ref_valid = 1; bus.ref_addr = 7'h07; #1;
    tick(); bus.ref_valid = 0; #1;
    tick(); bus.user_write_en = 1; bus.user_addr = 7'h07; bus.user_wdata = 32'h12345678; #1;
    n_tests++;
    if ({bus.arr_we, bus.arr_addr, bus.arr_wdata} !== {1'b1, 7'h07, 32'h12345678}) begin
      n_fail++; $display("FAIL wrhit_user: got we=%b addr=%h wdata=%h exp 1 07 12345678", bus.arr_we, bus.arr_addr, bus.arr_wdata);
    end
    tick(); bus.user_write_en = 0; #1;
    n_tests++;
    if ({bus.arr_we, bus.ref_done, bus.busy} !== 3'b010) begin
      n_fail++; $display("FAIL wrhit_drop: got we=%b done=%b busy=%b exp 0 1 0", bus.arr_we, bus.ref_done, bus.busy);
    end
    tick(); #1;
    n_tests++;
    if (mem[7] !== 32'h12345678) begin
      n_fail++; $display("FAIL wrhit_mem: got %h exp 12345678", mem[7]);
    end
  endtask

  task automatic test_rw_both();
    tick(); bus.user_read_en = 1; bus.user_write_en = 1; bus.user_addr = 7'h50; bus.user_wdata = 32'h00000055; #1;
    n_tests++;
    if ({bus.arr_re, bus.arr_we, bus.arr_wdata} !== {1'b0, 1'b1, 32'h00000055}) begin
      n_fail++; $display("FAIL rwboth_arr: got re=%b we=%b wdata=%h exp 0 1 00000055", bus.arr_re, bus.arr_we, bus.arr_wdata);
    end
    tick(); idle_inputs(); #1;
    n_tests++;
    if (bus.user_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rwboth_rvalid: got %b exp 0", bus.user_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    tick(); bus.ref_valid = 1; bus.ref_addr = 7'h60; #1;
    tick(); bus.ref_valid = 0; #1;
    tick(); rst_n = 0; #1;
    n_tests++;
    if ({bus.arr_re, bus.arr_we, bus.busy, bus.ref_ready, bus.ref_done, bus.arr_addr, bus.arr_wdata} !== 44'b0) begin
      n_fail++; $display("FAIL rstmid_out: got re=%b we=%b busy=%b rdy=%b done=%b addr=%h wdata=%h exp all 0",
                         bus.arr_re, bus.arr_we, bus.busy, bus.ref_ready, bus.ref_done, bus.arr_addr, bus.arr_wdata);
    end
    tick(); #1;
    n_tests++;
    if ({bus.ref_done, bus.arr_we} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_hold: got done=%b we=%b exp 0 0", bus.ref_done, bus.arr_we);
    end
    tick(); rst_n = 1; #1;
    tick(); #1;
    n_tests++;
    if ({bus.ref_done, bus.busy, bus.ref_ready} !== 3'b001) begin
      n_fail++; $display("FAIL rstmid_idle: got done=%b busy=%b rdy=%b exp 0 0 1", bus.ref_done, bus.busy, bus.ref_ready);
    end
    bus.ref_valid = 1; bus.ref_addr = 7'h61; #1;
    tick(); bus.ref_valid = 0; #1;
    tick(); #1;
    tick(); #1;
    n_tests++;
    if ({bus.arr_we, bus.arr_addr, bus.arr_wdata} !== {1'b1, 7'h61, 32'h61616161}) begin
      n_fail++; $display("FAIL rstmid_wb: got we=%b addr=%h wdata=%h exp 1 61 61616161", bus.arr_we, bus.arr_addr, bus.arr_wdata);
    end
    tick(); #1;
    n_tests++;
    if ({bus.ref_done, mem[7'h60]} !== {1'b1, 32'h60606060}) begin
      n_fail++; $display("FAIL rstmid_done: got done=%b mem60=%h exp 1 60606060", bus.ref_done, mem[7'h60]);
    end
  endtask

`ifdef REFRESH_EXEC_STATS_EN
  task automatic do_refresh(input logic [6:0] addr, input int stall);
    tick(); bus.ref_valid = 1; bus.ref_skip = 0; bus.ref_addr = addr; #1;
    tick(); bus.ref_valid = 0; #1;
    tick(); #1;
    for (int s = 0; s < stall; s++) begin
      tick(); bus.user_read_en = 1; bus.user_addr = 7'h70; #1;
    end
    tick(); bus.user_read_en = 0; #1;
    tick(); #1;
  endtask

  task automatic test_stats();
    tick(); rst_n = 0; #1;
    tick(); rst_n = 1; #1;
    n_tests++;
    if ({bus.ref_count, bus.stall_count} !== 32'h0) begin
      n_fail++; $display("FAIL stats_reset: got ref=%0d stall=%0d exp 0 0", bus.ref_count, bus.stall_count);
    end
    do_refresh(7'h01, 0);
    do_refresh(7'h02, 2);
    do_refresh(7'h03, 0);
    tick(); #1;
    n_tests++;
    if ({bus.ref_count, bus.stall_count} !== {16'd3, 16'd2}) begin
      n_fail++; $display("FAIL stats_count: got ref=%0d stall=%0d exp 3 2", bus.ref_count, bus.stall_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_refresh();
    test_skip();
    test_user_stall_wb();
    test_rd_stall();
    test_wr_hit_cap();
    test_rw_both();
    test_reset_mid();
`ifdef REFRESH_EXEC_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/refresh_exec.md
REFRESH_EXEC -- requirements
Module: refresh_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the array row data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 7, the row address width (128 rows).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 SHALL have port ref_valid, input, 1 bit, a refresh request from the selective-refresh tracker.
REQ-006 SHALL have port ref_addr, input, ADDR_W bits, the row to refresh.
REQ-007 SHALL have port ref_skip, input, 1 bit, the tracker indicator: row already fresh, so no array operation.
REQ-008 SHALL have port ref_ready, output, 1 bit, the request acceptance.
REQ-009 SHALL have port ref_done, output, 1 bit, a one-cycle pulse when a request completes.
REQ-010 SHALL have ports user_read_en and user_write_en, input, 1 bit each, the user access strobes.
REQ-011 SHALL have ports user_addr (ADDR_W) and user_wdata (DATA_W), input, the user row address and write data.
REQ-012 SHALL have ports user_rdata (DATA_W) and user_rvalid (1), output, the user read data and its qualifier.
REQ-013 SHALL have ports arr_re, arr_we (1 each), arr_addr (ADDR_W) and arr_wdata (DATA_W), output, the GC-DRAM array controls.
REQ-014 SHALL have port arr_rdata, input, DATA_W bits, the array read data, valid one cycle after arr_re.
REQ-015 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RD, CAP and WB, where RD issues arr_re, CAP registers arr_rdata and WB issues arr_we with the captured data.
REQ-017 SHALL drive ref_ready = IDLE and no user strobe this cycle; a request transfers when ref_valid and ref_ready are both high.
REQ-018 SHALL, on a transfer with ref_skip=1, perform no array operation, stay in IDLE and pulse ref_done the next cycle.
REQ-019 SHALL, on a transfer with ref_skip=0, latch ref_addr and take the path IDLE->RD->CAP->WB->IDLE; ref_done pulses in the cycle after the WB write is issued.
REQ-020 SHALL give a user strobe strict priority over refresh: the user access drives the array that cycle and a pending RD or WB stalls in place, holding its address and captured data.
REQ-021 SHALL, when user_write_en targets the latched refresh row while in CAP or WB, drop the write-back (user data is newer), return to IDLE and still pulse ref_done.
REQ-022 SHALL, for a user read, assert user_rvalid exactly one cycle after arr_re with user_rdata = arr_rdata.
REQ-023 SHALL ignore the read and leave user_rvalid low when user_read_en and user_write_en are both high; the write is performed.
REQ-024 SHALL NOT assert arr_re and arr_we together in any cycle.
REQ-025 SHALL never sample CAP data from a user read; a refresh read stalled by a user read is re-issued in RD.

Reset
REQ-026 SHALL, while rst_n=0, set state IDLE and drive 0 on ref_ready, ref_done, arr_re, arr_we, arr_addr, arr_wdata, user_rdata, user_rvalid and busy.
REQ-027 SHALL abandon an in-flight refresh without a write-back and without a ref_done pulse when reset asserts mid-operation.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with REFRESH_EXEC_STATS_EN defined, add 16-bit outputs ref_count (incremented per completed write-back) and stall_count (incremented per cycle a refresh stalls for a user access); both saturate at 0xFFFF and reset to 0.
REQ-030 SHALL, without REFRESH_EXEC_STATS_EN, omit those ports and counters entirely.

Verification
REQ-031 Scenario: ref_valid=1, ref_skip=0, ref_addr=0x05, arr_rdata=0xA5A5A5A5 -> arr_re@0x05 at T+1, arr_we@0x05 with 0xA5A5A5A5 at T+3, ref_done at T+4.
REQ-032 Scenario: ref_valid=1, ref_skip=1, ref_addr=0x10 -> no arr_re or arr_we, ref_done one cycle after transfer.
REQ-033 Scenario: refresh row 0x20 in WB while a user read of 0x30 is strobed for 2 cycles -> user reads served, user_rvalid 1 cycle after each, write-back to 0x20 issued on the first free cycle.
REQ-034 Scenario: refresh row 0x07 in CAP while a user write to 0x07 with 0x12345678 -> array holds 0x12345678, no refresh arr_we, ref_done pulses.
REQ-035 Scenario: rst_n low during CAP -> all outputs 0, no arr_we, no ref_done; after release, a new request completes normally.
REQ-036 Scenario: with REFRESH_EXEC_STATS_EN, 3 refreshes (one stalled 2 cycles) -> ref_count=3, stall_count=2.
